// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and key map for the matrix keypad scanner.
//   state_e      - debounce FSM states
//   scan_res_e   - classification of one complete 4x4 scan
//   key_kind_e   - what an accepted key does (data, guardar, finalizar)
//   key_info_t   - {kind, 4-bit code} returned by map_key()
//   map_key()    - translates a (row, col) position into key_info_t
package teclado_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConfirm,
        StEmit,
        StRelease
    } state_e;

    typedef enum logic [1:0] {
        ResNone,
        ResKey,
        ResMulti
    } scan_res_e;

    typedef enum logic [1:0] {
        KindData,
        KindGuardar,
        KindFinalizar
    } key_kind_e;

    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] code;
    } key_info_t;

    localparam logic [3:0] KeyCodeA = 4'd10;
    localparam logic [3:0] KeyCodeB = 4'd11;
    localparam logic [3:0] KeyCodeC = 4'd12;
    localparam logic [3:0] KeyCodeD = 4'd13;

    // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
    function automatic key_info_t map_key(input logic [1:0] row, input logic [1:0] col);
        key_info_t info;
        info.kind = KindData;
        info.code = 4'd0;
        case ({row, col})
            4'h0: info.code = 4'd1;
            4'h1: info.code = 4'd2;
            4'h2: info.code = 4'd3;
            4'h3: info.code = KeyCodeA;
            4'h4: info.code = 4'd4;
            4'h5: info.code = 4'd5;
            4'h6: info.code = 4'd6;
            4'h7: info.code = KeyCodeB;
            4'h8: info.code = 4'd7;
            4'h9: info.code = 4'd8;
            4'hA: info.code = 4'd9;
            4'hB: info.code = KeyCodeC;
            4'hC: info.kind = KindGuardar;
            4'hD: info.code = 4'd0;
            4'hE: info.kind = KindFinalizar;
            default: info.code = KeyCodeD;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/teclado_matricial_if.sv
// teclado_matricial_if: keypad pins plus the operator-input strobes.
//   fila      - keypad rows, active-low, asynchronous
//   columna   - keypad column drive, active-low, one-cold
//   entrada   - code of the last accepted data key
//   push      - one-cycle strobe, data key accepted
//   guardar   - one-cycle strobe, '*' accepted
//   finalizar - one-cycle strobe, '#' accepted
// master: the scanner; slave: the keypad/consumer side.
interface teclado_matricial_if;

    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] entrada;
    logic       push;
    logic       guardar;
    logic       finalizar;

    modport master (
        input  fila,
        output columna,
        output entrada,
        output push,
        output guardar,
        output finalizar
    );

    modport slave (
        output fila,
        input  columna,
        input  entrada,
        input  push,
        input  guardar,
        input  finalizar
    );

endinterface

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk  - destination clock
//   rst  - asynchronous active-low reset, loads RESET_VALUE
//   din  - asynchronous input
//   dout - synchronized output, two clocks behind din
module sincronizador_2ff #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/teclado_matricial.sv
// teclado_matricial: 4x4 matrix keypad scanner with debounce.
//   clk - system clock
//   rst - asynchronous active-low reset
//   kp  - keypad/strobe interface (master): drives columna, samples fila,
//         produces entrada plus single-cycle push/guardar/finalizar strobes.
// Each column is driven for SCAN_CYCLES clocks and its rows sampled on the last
// one; after column 3 the full scan is classified and fed to the debounce FSM.
module teclado_matricial
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES    = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic                 clk,
    input logic                 rst,
    teclado_matricial_if.master kp
);

    localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    // One extra state so the counter can actually hold DEBOUNCE_SCANS.
    localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
    localparam logic [CntW-1:0]   CntTarget = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);

    // ---------------- row synchronizer ----------------
    logic [3:0] fila_sync;

    // Rows idle high, so reset to "nothing pressed".
    sincronizador_2ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'hF)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (kp.fila),
        .dout (fila_sync)
    );

    // ---------------- column scanner ----------------
    logic [DwellW-1:0] dwell_q;
    logic [1:0]        col_q;
    logic              sample;
    logic              scan_done;

    assign sample    = (dwell_q == DwellLast);
    assign scan_done = sample && (col_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_q <= '0;
            col_q   <= 2'd0;
        end else if (sample) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + DwellW'(1);
        end
    end

    assign kp.columna = ~(4'b0001 << col_q);

    // ---------------- scan accumulation and decode ----------------
    // Bit {row, col} set means that key was seen pressed in the current scan.
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [4:0]  n_pressed;
    logic [3:0]  key_idx;
    scan_res_e   result;

    always_comb begin
        acc_d = acc_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                acc_d[{2'(r), col_q}] = ~fila_sync[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // acc_d already includes column 3 on the scan_done cycle.
    always_comb begin
        n_pressed = 5'd0;
        key_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (acc_d[i]) begin
                n_pressed = n_pressed + 5'd1;
                key_idx   = 4'(i);
            end
        end
        if (n_pressed == 5'd0) begin
            result = ResNone;
        end else if (n_pressed == 5'd1) begin
            result = ResKey;
        end else begin
            result = ResMulti;
        end
    end

    // ---------------- debounce FSM ----------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      entrada_q, entrada_d;
    logic            push_q, push_d;
    logic            guardar_q, guardar_d;
    logic            finalizar_q, finalizar_d;
    logic            goto_emit;
    key_info_t       kinfo;

    assign cnt_inc = cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        entrada_d   = entrada_q;
        push_d      = 1'b0;
        guardar_d   = 1'b0;
        finalizar_d = 1'b0;
        goto_emit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (scan_done && (result == ResKey)) begin
                    cand_d = key_idx;
                    cnt_d  = CntOne;
                    if (CntOne == CntTarget) begin
                        goto_emit = 1'b1;
                    end else begin
                        state_d = StConfirm;
                    end
                end
            end
            StConfirm: begin
                if (scan_done) begin
                    if (result == ResKey) begin
                        if (key_idx == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CntTarget) begin
                                goto_emit = 1'b1;
                            end
                        end else begin
                            cand_d = key_idx;
                            cnt_d  = CntOne;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            StEmit: begin
                state_d = StRelease;
                cnt_d   = '0;
            end
            StRelease: begin
                if (scan_done) begin
                    if (result == ResNone) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntTarget) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Strobes are registered so they coincide with the EMIT cycle.
        kinfo = map_key(cand_d[3:2], cand_d[1:0]);
        if (goto_emit) begin
            state_d = StEmit;
            case (kinfo.kind)
                KindData: begin
                    push_d    = 1'b1;
                    entrada_d = kinfo.code;
                end
                KindGuardar:   guardar_d   = 1'b1;
                KindFinalizar: finalizar_d = 1'b1;
                default:       push_d      = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            entrada_q   <= 4'd0;
            push_q      <= 1'b0;
            guardar_q   <= 1'b0;
            finalizar_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            entrada_q   <= entrada_d;
            push_q      <= push_d;
            guardar_q   <= guardar_d;
            finalizar_q <= finalizar_d;
        end
    end

    assign kp.entrada   = entrada_q;
    assign kp.push      = push_q;
    assign kp.guardar   = guardar_q;
    assign kp.finalizar = finalizar_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// tb_teclado_matricial: directed and randomized keypad stimulus, checked against
// a scan-level model of press acceptance (run lengths of identical scans).
module tb_teclado_matricial;

    localparam int unsigned SC      = 4;
    localparam int unsigned DB      = 3;
    localparam int          ScanLen = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    teclado_matricial_if kp();

    teclado_matricial #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Physical keypad: bit r*4+c pressed shorts row r to column c.
    logic [15:0] keys;
    logic [3:0]  noise;
    logic [3:0]  fila_kp;

    always_comb begin
        fila_kp = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp.columna[c]) fila_kp[r] = 1'b0;
            end
        end
        kp.fila = fila_kp ^ noise;
    end

    typedef struct {
        int cyc;
        int kind;  // 0 push, 1 guardar, 2 finalizar
        int code;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int scan_idx;
    bit glitch_en;
    int code_tab[16];

    // Model state
    bit m_ready;
    int m_key;
    int m_run;
    int m_empty;
    int m_entrada;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ready   = 1'b1;
        m_key     = -1;
        m_run     = 0;
        m_empty   = 0;
        m_entrada = 0;
        cyc       = 0;
        scan_idx  = 0;
    endtask

    // A press is accepted after DB consecutive scans showing the same single key;
    // then DB consecutive empty scans are needed before another can start.
    task automatic model_step(input logic [15:0] k);
        int  n;
        int  idx;
        ev_t ev;
        n   = $countones(k);
        idx = 0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        if (m_ready) begin
            if (n == 1) begin
                if (idx == m_key) m_run++;
                else begin
                    m_key = idx;
                    m_run = 1;
                end
                if (m_run == DB) begin
                    ev.cyc = ScanLen * (scan_idx + 1);
                    if (code_tab[idx] == -1) ev.kind = 1;
                    else if (code_tab[idx] == -2) ev.kind = 2;
                    else begin
                        ev.kind   = 0;
                        m_entrada = code_tab[idx];
                    end
                    ev.code = m_entrada;
                    exp_q.push_back(ev);
                    m_ready = 1'b0;
                    m_empty = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_empty++;
                if (m_empty == DB) begin
                    m_ready = 1'b1;
                    m_run   = 0;
                end
            end else begin
                m_empty = 0;
            end
        end
    endtask

    task automatic tick();
        ev_t        ev;
        logic [3:0] col_exp;
        @(negedge clk);
        cyc++;
        // Glitches confined to the dwell cycles the scanner must ignore.
        noise   = (glitch_en && (cyc % 4 >= 2)) ? 4'($urandom) : 4'h0;
        col_exp = ~(4'b0001 << ((cyc / 4) % 4));
        chk("columna", 32'(kp.columna), 32'(col_exp));
        chk("strobe_onehot0", 32'($onehot0({kp.push, kp.guardar, kp.finalizar})), 32'd1);
        if (kp.push || kp.guardar || kp.finalizar) begin
            ev.cyc  = cyc;
            ev.kind = kp.push ? 0 : (kp.guardar ? 1 : 2);
            ev.code = int'(kp.entrada);
            got_q.push_back(ev);
        end
    endtask

    task automatic do_scan(input logic [15:0] k, input int n);
        for (int s = 0; s < n; s++) begin
            keys = k;
            model_step(k);
            for (int i = 0; i < ScanLen; i++) tick();
            scan_idx++;
        end
    endtask

    task automatic check_events(input string tag);
        int m;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_cycle"}, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
            chk({tag, "_kind"}, 32'(got_q[i].kind), 32'(exp_q[i].kind));
            chk({tag, "_entrada"}, 32'(got_q[i].code), 32'(exp_q[i].code));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] pat;
        int          hold;
        int          r;

        code_tab = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -2, 13};
        keys      = 16'h0;
        noise     = 4'h0;
        glitch_en = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_columna", 32'(kp.columna), 32'(4'b1110));
        chk("rst_entrada", 32'(kp.entrada), 32'd0);
        chk("rst_push", 32'(kp.push), 32'd0);
        chk("rst_guardar", 32'(kp.guardar), 32'd0);
        chk("rst_finalizar", 32'(kp.finalizar), 32'd0);
        rst = 1'b1;
        chk("rel_columna", 32'(kp.columna), 32'(4'b1110));

        // Idle scans: column stepping only
        do_scan(16'h0, 2);
        check_events("idle");

        // Clean press of '5'
        do_scan(16'h0001 << 5, 10);
        do_scan(16'h0, 4);
        check_events("press5");
        chk("entrada5", 32'(kp.entrada), 32'd5);

        // Bouncing '7' with mid-dwell glitches
        glitch_en = 1'b1;
        do_scan(16'h0001 << 8, 1);
        do_scan(16'h0, 1);
        do_scan(16'h0001 << 8, 1);
        do_scan(16'h0, 1);
        do_scan(16'h0001 << 8, 5);
        do_scan(16'h0, 4);
        check_events("bounce7");
        chk("entrada7", 32'(kp.entrada), 32'd7);

        // Control keys after '9'
        do_scan(16'h0001 << 10, 4);
        do_scan(16'h0, 4);
        do_scan(16'h0001 << 12, 4);
        do_scan(16'h0, 4);
        chk("entrada9_after_guardar", 32'(kp.entrada), 32'd9);
        do_scan(16'h0001 << 14, 4);
        do_scan(16'h0, 4);
        check_events("control");
        chk("entrada9_after_finalizar", 32'(kp.entrada), 32'd9);

        // '1' and '2' together, then '2' released
        do_scan(16'h0003, 5);
        do_scan(16'h0001, 4);
        do_scan(16'h0, 4);
        check_events("multi");
        chk("entrada1", 32'(kp.entrada), 32'd1);

        // Reset asserted mid-CONFIRM with 'A' held
        do_scan(16'h0001 << 3, 2);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b0;
        #1;
        chk("midrst_columna", 32'(kp.columna), 32'(4'b1110));
        chk("midrst_entrada", 32'(kp.entrada), 32'd0);
        chk("midrst_push", 32'(kp.push), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_strobes", 32'({kp.push, kp.guardar, kp.finalizar}), 32'd0);
        check_events("pre_reset");
        rst = 1'b1;
        model_reset();
        do_scan(16'h0001 << 3, 4);
        do_scan(16'h0, 4);
        check_events("after_reset");
        chk("entrada10", 32'(kp.entrada), 32'd10);

        // Randomized key patterns
        hold = 0;
        pat  = 16'h0;
        for (int i = 0; i < 48; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3) pat = 16'h0;
                else if (r < 9) pat = 16'h0001 << $urandom_range(0, 15);
                else pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                hold = $urandom_range(1, 5);
            end
            do_scan(pat, 1);
            hold--;
        end
        do_scan(16'h0, 4);
        check_events("random");
        chk("entrada_random", 32'(kp.entrada), 32'(m_entrada));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
